// File: rtl/crossfile_pkg.sv
// Shared types for the crossfile producer/consumer path.
package crossfile_pkg;

    localparam int FIFO_DEPTH = 8;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] payload;
    } transaction_t;

endpackage

// File: rtl/crossfile_fifo.sv
// Single-clock show-ahead FIFO with valid/ready on both sides, arbitrary depth,
// occupancy count, almost-full flag, synchronous flush and peak-occupancy monitor.
module crossfile_fifo #(
    parameter int WIDTH     = $bits(crossfile_pkg::transaction_t),
    parameter int DEPTH     = crossfile_pkg::FIFO_DEPTH,
    parameter int AF_THRESH = DEPTH - 1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic             almost_full,
    output logic [CW-1:0]    max_count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] max_count_q, max_count_d;

    logic push;
    logic pop;

    // Handshake flags come from registered occupancy only, so there is no
    // combinational path between the two sides.
    assign in_ready    = rst_n && (count_q != CW'(DEPTH));
    assign out_valid   = (count_q != '0);
    assign out_data    = mem[rd_ptr_q];
    assign count       = count_q;
    assign max_count   = max_count_q;
    assign almost_full = (count_q >= CW'(AF_THRESH));

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        max_count_d = max_count_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            max_count_d = '0;
        end else begin
            // Explicit wrap: depth need not be a power of two.
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
            max_count_d = (count_d > max_count_q) ? count_d : max_count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            max_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            max_count_q <= max_count_d;
        end
    end

    // Storage has no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    a_in_data_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (in_valid && !in_ready) |=> $stable(in_data)
    );

endmodule

// File: tb/tb_crossfile_fifo.sv
// Bench for crossfile_fifo: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based model.
module tb_crossfile_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 5;
    localparam int AFT   = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             almost_full;
    logic [CW-1:0]    max_count;

    int errors = 0;
    int checks = 0;
    bit acc;

    logic [WIDTH-1:0] mq[$];
    int mmax = 0;

    crossfile_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AFT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .count      (count),
        .almost_full(almost_full),
        .max_count  (max_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    // Inputs are settled; note acceptance, advance one edge, sample 1ns after it.
    task automatic tick();
        #1;
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
    endtask

    // Reference model: occupancy is a queue, decisions follow the handshake rules.
    always @(posedge clk) begin
        bit do_push, do_pop;
        if (!rst_n || flush) begin
            mq.delete();
            mmax = 0;
        end else begin
            do_push = in_valid && (mq.size() != DEPTH);
            do_pop  = out_ready && (mq.size() != 0);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(in_data);
            if (mq.size() > mmax) mmax = mq.size();
        end
    end

    always @(negedge clk) begin
        chk("m_in_ready", int'(in_ready), int'(rst_n && (mq.size() != DEPTH)));
        chk("m_out_valid", int'(out_valid), int'(mq.size() != 0));
        chk("m_count", int'(count), mq.size());
        chk("m_almost_full", int'(almost_full), int'(mq.size() >= AFT));
        chk("m_max_count", int'(max_count), mmax);
        if (mq.size() != 0) chk("m_out_data", int'(out_data), int'(mq[0]));
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;

        // Reset held with a producer pushing: nothing enters.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_in_ready", int'(in_ready), 0);
            chk("rst_count", int'(count), 0);
            chk("rst_out_valid", int'(out_valid), 0);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk("rel_in_ready", int'(in_ready), 1);
        tick();
        chk("rel_count", int'(count), 0);

        // Fill and drain three times to cross the pointer wrap.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                in_valid = 1'b1; in_data = 8'h11 + 8'(i);
                tick();
                chk("fill_count", int'(count), i + 1);
                chk("fill_af", int'(almost_full), int'(i + 1 >= 4));
                chk("fill_in_ready", int'(in_ready), int'(i + 1 < 5));
            end
            in_valid = 1'b0; out_ready = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                #1;
                chk("drain_valid", int'(out_valid), 1);
                chk("drain_data", int'(out_data), 8'h11 + i);
                tick();
            end
            out_ready = 1'b0;
            chk("drain_count", int'(count), 0);
            chk("drain_max", int'(max_count), 5);
        end

        // Full with simultaneous pop: only the pop happens.
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1; in_data = 8'h21 + 8'(i);
            tick();
        end
        in_valid = 1'b1; in_data = 8'h26; out_ready = 1'b1;
        #1;
        chk("full_in_ready", int'(in_ready), 0);
        tick();
        chk("full_pop_count", int'(count), 4);
        chk("full_pop_head", int'(out_data), 8'h22);
        tick();
        chk("full_next_count", int'(count), 4);
        in_valid = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        chk("stream_pre_count", int'(count), 2);

        // Streaming at full rate with occupancy two.
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1; out_ready = 1'b1; in_data = 8'h30 + 8'(k);
            #1;
            chk("stream_data", int'(out_data), (k == 0) ? 8'h25 : (k == 1) ? 8'h26 : 8'h30 + k - 2);
            tick();
            chk("stream_count", int'(count), 2);
        end
        out_ready = 1'b0; in_data = 8'h50;
        tick();
        chk("flush_pre_count", int'(count), 3);

        // Flush wins over a coincident push and pop.
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h51; out_ready = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_count", int'(count), 0);
        chk("flush_max", int'(max_count), 0);
        chk("flush_out_valid", int'(out_valid), 0);
        chk("flush_in_ready", int'(in_ready), 1);
        in_valid = 1'b1; in_data = 8'h60; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("post_flush_head", int'(out_data), 8'h60);
        chk("post_flush_count", int'(count), 1);
        chk("post_flush_max", int'(max_count), 1);

        // Random backpressure, with rare flush and one mid-run reset.
        for (int c = 0; c < 1000; c++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 50);
            flush     = ($urandom_range(0, 199) == 0);
            rst_n     = !(c >= 500 && c < 502);
            if (acc) in_data = 8'($urandom);
            tick();
        end
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
